clock_set_ctrl: RTL and testbench
=================================

// Module: clock_set_ctrl
// PURPOSE
//   Time-set controller for the 12-hour digital clock. Turns two raw push-buttons (MODE, INC)
//   into the level advance requests adv_hr/adv_min that the clock datapath samples on its
//   1 Hz period enable. Also drives per-field blink flags for the display.
//   Sits between the board buttons and the clock top level. Shares the clock's tick_1hz enable.
// PARAMETERS
//   CLK_HZ       100_000_000  system clock frequency, used to size the debounce counter
//   DEBOUNCE_MS  20           time a synchronised input must stay stable before it is accepted
//   TIMEOUT_S    10           tick_1hz periods with no press in a set mode before returning to RUN
//   HOLD_TICKS   2            ticks INC must be held before auto-repeat starts (CLKSET_AUTOREPEAT_EN only)
// PORTS
//   clk        in   1  system clock
//   rst        in   1  asynchronous, active-low reset
//   btn_mode   in   1  raw MODE button, asynchronous, active-high
//   btn_inc    in   1  raw INC button, asynchronous, active-high
//   tick_1hz   in   1  one-cycle 1 Hz enable from the clock's period_enb
//   adv_hr     out  1  level request: advance hours on the next tick_1hz
//   adv_min    out  1  level request: advance minutes on the next tick_1hz
//   set_mode   out  2  current state: 00 RUN, 01 SET_HR, 10 SET_MIN
//   blink_hr   out  1  hour digits blank phase (1 = blank)
//   blink_min  out  1  minute digits blank phase (1 = blank)
// BEHAVIOUR
//   - Reset: every output is 0; state is RUN; pending, blink-phase, idle and debounce state are cleared.
//   - Input conditioning per button:
//     - 2-FF synchroniser, then a debouncer with DB_CYC = CLK_HZ/1000*DEBOUNCE_MS.
//     - The debounced level changes only after the synchronised value has differed from it for
//       DB_CYC consecutive cycles.
//     - press = one-cycle pulse on the debounced rising edge.
//     - Latency from raw edge to press pulse: 2 + DB_CYC cycles.
//   - State machine:
//     - A MODE press steps RUN -> SET_HR -> SET_MIN -> RUN. There is no encoding 11; it decodes as RUN.
//   - Requests:
//     - An INC press in SET_HR sets pend_hr; in SET_MIN it sets pend_min. In RUN it is ignored.
//     - adv_hr = pend_hr and adv_min = pend_min (registered).
//     - A pending flag clears on the cycle after a cycle with tick_1hz=1. This is the handshake:
//       the request is high during the tick cycle and the datapath advances exactly once.
//     - A press while the flag is already pending is dropped (no queueing). At most 1 advance per tick.
//     - A press in the same cycle as the clearing tick re-arms the flag for the next tick.
//   - Pending flags survive state changes, including timeout. They are delivered at the next tick.
//   - Simultaneous MODE and INC presses: INC is evaluated against the pre-transition state, and both take effect.
//   - Timeout:
//     - The idle counter increments on tick_1hz in SET_HR or SET_MIN and resets on any press.
//     - On the tick that brings it to TIMEOUT_S, state becomes RUN. The counter is held at 0 in RUN.
//   - Blink:
//     - blink_ph toggles on every tick_1hz.
//     - blink_hr = (state==SET_HR) & blink_ph; blink_min = (state==SET_MIN) & blink_ph.
//   - Reset asserted mid-operation drops pending requests immediately. No advance is issued.
// CONFIGURATION
//   CLKSET_AUTOREPEAT_EN defined:
//     - While the debounced INC stays high in a set state for >= HOLD_TICKS ticks, the matching
//       pending flag is re-set on every tick_1hz, giving a continuous advance of 1 per second.
//     - Releasing INC stops it. A hold counter saturates at HOLD_TICKS.
//   Not defined:
//     - One advance per press. There is no hold counter.
// STRUCTURE
//   - clock_pkg holds:
//     - typedef enum logic [1:0] set_state_t {RUN=2'b00, SET_HR=2'b01, SET_MIN=2'b10}
//     - localparam function db_cycles(CLK_HZ, DEBOUNCE_MS)
//   - Sub-module btn_debounce (synchroniser + debounce counter + press pulse), instantiated twice.
//   - This module holds the FSM, the pending flags, the idle/hold counters and the blink phase.
// TESTING  (bench parameters: CLK_HZ=1000, DEBOUNCE_MS=3 -> DB_CYC=3; TIMEOUT_S=4; tick_1hz every 10 cycles)
//   1. Raw btn_inc glitch high for 2 cycles -> no press and no adv change.
//      Held 10 cycles -> exactly one press, at cycle 5.
//   2. MODE press then INC press -> set_mode=01 and adv_hr=1 until the cycle after the next tick.
//      The hour datapath model increments exactly once.
//   3. Three INC presses within one tick period in SET_MIN -> adv_min high for a single tick.
//      The minute count advances by exactly 1.
//   4. Enter SET_HR, then no presses -> set_mode returns to 00 on the 4th tick.
//      blink_hr toggles each tick while in SET_HR and is 0 afterwards.
//   5. Simultaneous MODE and INC press in SET_HR -> set_mode=10, adv_hr=1, adv_min=0.
//      Drop rst during pending adv_min -> outputs 0 at once; no advance on the next tick.
//   6. With CLKSET_AUTOREPEAT_EN: hold INC 6 ticks in SET_MIN -> adv_min on ticks 1, 3, 4, 5, 6.
//      Without it: tick 1 only.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and helpers for the 12-hour clock time-set logic.
package clock_pkg;

  // Time-set state; encoding 2'b11 is never produced and behaves as RUN.
  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } set_state_t;

  // Bit positions of the two buttons inside the conditioned button vectors.
  localparam int BTN_MODE = 0;
  localparam int BTN_INC  = 1;

  // Number of system clock cycles a button must be steady before it is accepted.
  function automatic int db_cycles(input int clk_hz, input int debounce_ms);
    return clk_hz / 1000 * debounce_ms;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-FF synchroniser, stability counter and a one-cycle
// press pulse on the accepted rising edge. Raw edge to press pulse is 2 + DB_CYC cycles.
module btn_debounce
  import clock_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int DB_CYC = db_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int CW     = $clog2(DB_CYC + 1);

  logic [1:0]    sync_reg;
  logic          level_reg;
  logic          press_reg;
  logic [CW-1:0] cnt_reg;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_reg <= '0;
    else      sync_reg <= {sync_reg[0], btn};
  end

  // Accept a new level only after DB_CYC consecutive disagreeing samples; pulse on acceptance of a 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      press_reg <= 1'b0;
    end else begin
      press_reg <= 1'b0;
      if (sync_reg[1] == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CW'(DB_CYC - 1)) begin
        cnt_reg   <= '0;
        level_reg <= sync_reg[1];
        press_reg <= sync_reg[1];
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign level = level_reg;
  assign press = press_reg;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set controller: MODE steps RUN -> SET_HR -> SET_MIN -> RUN, INC raises a
// level advance request that the datapath consumes on its next tick_1hz.
// Optional feature macro: CLKSET_AUTOREPEAT_EN (hold INC for continuous advance).
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int TIMEOUT_S   = 10,
  parameter int HOLD_TICKS  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       tick_1hz,
  output logic       adv_hr,
  output logic       adv_min,
  output logic [1:0] set_mode,
  output logic       blink_hr,
  output logic       blink_min
);

  localparam int IW = $clog2(TIMEOUT_S + 1);

  logic [1:0] btn_raw;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic       mode_press;
  logic       inc_press;
  logic       in_set;
  logic       repeat_fire;
  logic       unused_ok;

  set_state_t    state_reg, state_next;
  logic          pend_hr_reg, pend_hr_next;
  logic          pend_min_reg, pend_min_next;
  logic [IW-1:0] idle_reg, idle_next;
  logic          blink_ph_reg;

  assign btn_raw = {btn_inc, btn_mode};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    btn_debounce #(
      .CLK_HZ      (CLK_HZ),
      .DEBOUNCE_MS (DEBOUNCE_MS)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_raw[gi]),
      .level (btn_level[gi]),
      .press (btn_press[gi])
    );
  end

  assign mode_press = btn_press[BTN_MODE];
  assign inc_press  = btn_press[BTN_INC];
  assign in_set     = (state_reg == SET_HR) || (state_reg == SET_MIN);

`ifdef CLKSET_AUTOREPEAT_EN
  localparam int HW = $clog2(HOLD_TICKS + 1);
  logic [HW-1:0] hold_reg;

  // Count ticks while INC is held in a set state, saturating at HOLD_TICKS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                           hold_reg <= '0;
    else if (!in_set || !btn_level[BTN_INC])            hold_reg <= '0;
    else if (tick_1hz && hold_reg != HW'(HOLD_TICKS))   hold_reg <= hold_reg + 1'b1;
  end

  // The tick on which the hold count reaches HOLD_TICKS, and every tick after, re-arms a request.
  assign repeat_fire = tick_1hz & btn_level[BTN_INC] & in_set & (hold_reg >= HW'(HOLD_TICKS - 1));
  assign unused_ok   = &{1'b0, btn_level[BTN_MODE]};
`else
  assign repeat_fire = 1'b0;
  // Debounced levels only matter for auto-repeat.
  assign unused_ok   = &{1'b0, btn_level, (HOLD_TICKS != 0)};
`endif

  // State, request and idle registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= RUN;
      pend_hr_reg  <= 1'b0;
      pend_min_reg <= 1'b0;
      idle_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      pend_hr_reg  <= pend_hr_next;
      pend_min_reg <= pend_min_next;
      idle_reg     <= idle_next;
    end
  end

  // Requests drop after the tick that delivered them; presses see the pre-transition state.
  always_comb begin
    state_next    = state_reg;
    pend_hr_next  = pend_hr_reg & ~tick_1hz;
    pend_min_next = pend_min_reg & ~tick_1hz;
    idle_next     = idle_reg;

    case (state_reg)
      SET_HR:  if (inc_press || repeat_fire) pend_hr_next = 1'b1;
      SET_MIN: if (inc_press || repeat_fire) pend_min_next = 1'b1;
      default: ;
    endcase

    if (mode_press) begin
      idle_next = '0;
      case (state_reg)
        SET_HR:  state_next = SET_MIN;
        SET_MIN: state_next = RUN;
        default: state_next = SET_HR;
      endcase
    end else if (in_set) begin
      // An auto-repeat advance counts as user activity, so holding INC never times out.
      if (inc_press || repeat_fire) begin
        idle_next = '0;
      end else if (tick_1hz) begin
        if (idle_reg == IW'(TIMEOUT_S - 1)) begin
          idle_next  = '0;
          state_next = RUN;
        end else begin
          idle_next = idle_reg + 1'b1;
        end
      end
    end else begin
      idle_next = '0;
    end
  end

  // Display blink phase flips once per second.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) blink_ph_reg <= 1'b0;
    else      blink_ph_reg <= blink_ph_reg ^ tick_1hz;
  end

  assign adv_hr    = pend_hr_reg;
  assign adv_min   = pend_min_reg;
  assign set_mode  = state_reg;
  assign blink_hr  = (state_reg == SET_HR) & blink_ph_reg;
  assign blink_min = (state_reg == SET_MIN) & blink_ph_reg;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl with a behavioural reference model.
module tb_clock_set_ctrl;

  localparam int CLK_HZ      = 1000;
  localparam int DEBOUNCE_MS = 3;
  localparam int TIMEOUT_S   = 4;
  localparam int HOLD_TICKS  = 2;
  localparam int DB          = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       adv_hr, adv_min, blink_hr, blink_min;
  logic [1:0] set_mode;

  always #5 clk = ~clk;

  clock_set_ctrl #(
    .CLK_HZ      (CLK_HZ),
    .DEBOUNCE_MS (DEBOUNCE_MS),
    .TIMEOUT_S   (TIMEOUT_S),
    .HOLD_TICKS  (HOLD_TICKS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .tick_1hz  (tick_1hz),
    .adv_hr    (adv_hr),
    .adv_min   (adv_min),
    .set_mode  (set_mode),
    .blink_hr  (blink_hr),
    .blink_min (blink_min)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int tcnt = 0;
  int tick_period = 10;
  int tick_count = 0;
  int cyc_fail_prints = 0;

  // Reference model state
  logic [DB+1:0] hist_m = '0, hist_i = '0;   // raw samples, bit 0 newest
  bit lvl_m, lvl_i, pm, pi;
  int m_mode, m_idle, m_hold;
  bit m_phr, m_pmin, m_ph;

  // Observations
  int dp_hr = 0, dp_min = 0;
  int inc_press_n = 0, last_inc_cyc = -1, ip_ticks = 0, ip_min = 0, mp_ticks = 0;

  // Debounced level flips once the raw button, seen 2 samples late, has disagreed for DB samples.
  function automatic bit settles(logic [DB+1:0] h, bit lvl);
    logic [DB-1:0] w;
    w = h[DB+1:2];
    return lvl ? (w == '0) : (w == '1);
  endfunction

  // Behavioural model of the controller, advanced on every clock edge.
  always @(posedge clk) begin : model
    bit cpm, cpi, ctk, cli, fire;
    if (!rst) begin
      hist_m = '0; hist_i = '0; lvl_m = 0; lvl_i = 0; pm = 0; pi = 0;
      m_mode = 0; m_idle = 0; m_hold = 0; m_phr = 0; m_pmin = 0; m_ph = 0;
    end else begin
      cpm = pm; cpi = pi; ctk = tick_1hz; cli = lvl_i; fire = 0;
      hist_m = {hist_m[DB:0], btn_mode};
      hist_i = {hist_i[DB:0], btn_inc};
      pm = 0; pi = 0;
      if (settles(hist_m, lvl_m)) begin lvl_m = ~lvl_m; pm = lvl_m; end
      if (settles(hist_i, lvl_i)) begin lvl_i = ~lvl_i; pi = lvl_i; end
`ifdef CLKSET_AUTOREPEAT_EN
      if (m_mode != 0 && cli) begin
        if (ctk) begin
          fire = (m_hold + 1 >= HOLD_TICKS);
          if (m_hold < HOLD_TICKS) m_hold++;
        end
      end else m_hold = 0;
`endif
      if (ctk) begin m_phr = 0; m_pmin = 0; end
      if ((cpi || fire) && m_mode == 1) m_phr = 1;
      if ((cpi || fire) && m_mode == 2) m_pmin = 1;
      if (cpm) begin
        m_mode = (m_mode + 1) % 3;
        m_idle = 0;
      end else if (m_mode != 0) begin
        if (cpi || fire) m_idle = 0;
        else if (ctk) begin
          m_idle++;
          if (m_idle == TIMEOUT_S) begin m_mode = 0; m_idle = 0; end
        end
      end
      m_ph ^= ctk;
    end
  end

  // Clock datapath stand-in: counts advances actually taken on ticks.
  always @(posedge clk) begin
    if (tick_1hz && adv_hr)  dp_hr++;
    if (tick_1hz && adv_min) dp_min++;
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin : compare
    logic [5:0] act, exp_v;
    act = {adv_hr, adv_min, set_mode, blink_hr, blink_min};
    if (!rst) exp_v = '0;
    else exp_v = {m_phr, m_pmin, 2'(m_mode), (m_mode == 1) && m_ph, (m_mode == 2) && m_ph};
    checks++;
    if (act !== exp_v) begin
      failures++;
      if (cyc_fail_prints < 20) begin
        cyc_fail_prints++;
        $display("FAIL cycle_compare cyc=%0d got {adv_hr,adv_min,mode,bh,bm}=%b want=%b", cyc, act, exp_v);
      end
    end
    if (rst) begin
      if (pi) begin inc_press_n++; last_inc_cyc = cyc; ip_ticks = tick_count; ip_min = dp_min; end
      if (pm) mp_ticks = tick_count;
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (tcnt >= tick_period - 1) begin
      tcnt = 0; tick_1hz = 1'b1; tick_count++;
    end else begin
      tcnt++; tick_1hz = 1'b0;
    end
  endtask

  task automatic press_btn(input bit m, input bit i);
    btn_mode = m; btn_inc = i;
    repeat (6) step();
    btn_mode = 0; btn_inc = 0;
    repeat (6) step();
  endtask

  task automatic wait_tick();
    int g = 0;
    step();
    while (!tick_1hz && g < 200) begin step(); g++; end
    if (!tick_1hz) bound_fail("wait_tick");
  endtask

  task automatic wait_ticks(input int n);
    int t0 = tick_count;
    int g = 0;
    while (tick_count < t0 + n && g < 500) begin step(); g++; end
    if (tick_count < t0 + n) bound_fail("wait_ticks");
    step();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int c0, n0, h0, m0, g, want_rep;
    repeat (4) step();
    check("reset_outputs", int'({adv_hr, adv_min, set_mode, blink_hr, blink_min}), 0);
    rst = 1'b1;
    repeat (3) step();

    // 1: glitch rejected, held press accepted exactly once at +5
    n0 = inc_press_n;
    btn_inc = 1; step(); step(); btn_inc = 0;
    repeat (8) step();
    check("glitch_no_press", inc_press_n - n0, 0);
    c0 = cyc + 1;
    step(); btn_inc = 1;
    repeat (10) step(); btn_inc = 0;
    repeat (8) step();
    check("held_one_press", inc_press_n - n0, 1);
    check("press_latency", last_inc_cyc - c0, 5);
    $display("txn 1: debounce glitch/held done at cyc %0d", cyc);

    // 2: MODE then INC -> one hour advance
    press_btn(1, 0);
    check("t2_set_mode", set_mode, 1);
    h0 = dp_hr;
    press_btn(0, 1);
    wait_ticks(2);
    check("t2_hr_once", dp_hr - h0, 1);
    $display("txn 2: hour advance, dp_hr=%0d", dp_hr);

    // 3: three INC presses in one (stretched) tick period in SET_MIN -> one advance
    press_btn(1, 0);
    check("t3_set_mode", set_mode, 2);
    tick_period = 40;
    wait_tick();
    m0 = dp_min;
    press_btn(0, 1); press_btn(0, 1); press_btn(0, 1);
    check("t3_adv_min_pending", adv_min, 1);
    wait_ticks(2);
    check("t3_min_once", dp_min - m0, 1);
    tick_period = 10;
    $display("txn 3: minute advance, dp_min=%0d", dp_min);

    // 4: timeout from SET_HR on the 4th tick
    press_btn(1, 0);
    press_btn(1, 0);
    check("t4_set_mode", set_mode, 1);
    g = 0;
    while (set_mode != 2'b00 && g < 100) begin step(); g++; end
    if (set_mode != 2'b00) bound_fail("t4_timeout");
    check("t4_timeout_ticks", tick_count - mp_ticks, TIMEOUT_S);
    wait_ticks(1);
    check("t4_blink_hr_off", blink_hr, 0);
    $display("txn 4: timeout after %0d ticks", tick_count - mp_ticks);

    // 5: simultaneous MODE+INC in SET_HR, then reset during pending adv_min
    press_btn(1, 0);
    btn_mode = 1; btn_inc = 1;
    repeat (6) step();
    check("t5_set_mode", set_mode, 2);
    check("t5_adv_hr", adv_hr, 1);
    check("t5_adv_min", adv_min, 0);
    btn_mode = 0; btn_inc = 0;
    repeat (6) step();
    wait_ticks(1);
    btn_inc = 1;
    g = 0;
    while (adv_min != 1'b1 && g < 20) begin step(); g++; end
    if (adv_min != 1'b1) bound_fail("t5_adv_min_wait");
    #2 rst = 1'b0;
    #1 check("t5_reset_outputs", int'({adv_hr, adv_min, set_mode, blink_hr, blink_min}), 0);
    m0 = dp_min;
    btn_inc = 0;
    repeat (3) step();
    rst = 1'b1;
    wait_ticks(2);
    check("t5_no_advance", dp_min - m0, 0);
    check("t5_mode_run", set_mode, 0);
    $display("txn 5: simultaneous press + reset, dp_min=%0d", dp_min);

    // 6: hold INC for 6 ticks in SET_MIN
    press_btn(1, 0);
    press_btn(1, 0);
    check("t6_set_mode", set_mode, 2);
    wait_tick();
    btn_inc = 1;
    repeat (6) step();
    g = 0;
    while (tick_count < ip_ticks + 6 && g < 200) begin step(); g++; end
    if (tick_count < ip_ticks + 6) bound_fail("t6_hold");
    step();
`ifdef CLKSET_AUTOREPEAT_EN
    want_rep = 5;
`else
    want_rep = 1;
`endif
    check("t6_hold_advances", dp_min - ip_min, want_rep);
    btn_inc = 0;
    repeat (8) step();
    $display("txn 6: hold advances=%0d", dp_min - ip_min);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
